// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM arbiter: one-hot FSM encoding, op codes and default widths.
package eeprom_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;

  localparam logic [4:0] ST_IDLE     = 5'b00001;
  localparam logic [4:0] ST_ISSUE    = 5'b00010;
  localparam logic [4:0] ST_WAIT_ACK = 5'b00100;
  localparam logic [4:0] ST_DONE     = 5'b01000;
  localparam logic [4:0] ST_WR_HOLD  = 5'b10000;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eeprom_rr_arb2.sv
// Combinational two-way round-robin grant: the pointer port wins when it requests.
module eeprom_rr_arb2
  import eeprom_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = req[ptr] ? ptr : ~ptr;
  end

endmodule

// File: rtl/eeprom_arbiter.sv
// Shares one serial EEPROM engine between CPU (port 0) and config loader (port 1).
// Optional ACK timeout abort is enabled by defining EEPROM_ARB_TIMEOUT_EN.
module eeprom_arbiter
  import eeprom_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TWR_CYCLES     = 5000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              eep_wr,
  output logic              eep_rd,
  output logic [ADDR_W-1:0] eep_addr,
  output logic [DATA_W-1:0] eep_wdata,
  input  logic              eep_ack,
  input  logic [DATA_W-1:0] eep_rdata
);

  // One counter serves both the ACK timeout and the write-cycle hold.
  localparam int CNT_W    = $clog2(max2(TWR_CYCLES, TIMEOUT_CYCLES) + 2);
  localparam int TWR_LAST = (TWR_CYCLES == 0) ? 0 : TWR_CYCLES - 1;
`ifdef EEPROM_ARB_TIMEOUT_EN
  localparam int TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
`endif

  logic [4:0]        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              port_q, port_d;
  logic              op_q, op_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic gnt_valid;
  logic gnt_idx;

  eeprom_rr_arb2 u_arb (
    .req       ({req1, req0}),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    port_d  = port_q;
    op_d    = op_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          port_d  = gnt_idx;
          op_d    = gnt_idx ? we1 : we0;
          addr_d  = gnt_idx ? addr1 : addr0;
          wdata_d = gnt_idx ? wdata1 : wdata0;
          err_d   = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (eep_ack) begin
          if (op_q == OP_RD) begin
            rdata_d = eep_rdata;
          end
          state_d = ST_DONE;
        end
`ifdef EEPROM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_LAST)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      // A timed-out access also gets the hold so the engine can recover.
      ST_DONE: begin
        ptr_d   = ~port_q;
        cnt_d   = '0;
        state_d = ((op_q == OP_WR) || err_q) ? ST_WR_HOLD : ST_IDLE;
      end
      ST_WR_HOLD: begin
        if (cnt_q == CNT_W'(TWR_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      port_q  <= 1'b0;
      op_q    <= OP_RD;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      port_q  <= port_d;
      op_q    <= op_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    eep_wr    = (state_q == ST_ISSUE) && (op_q == OP_WR);
    eep_rd    = (state_q == ST_ISSUE) && (op_q == OP_RD);
    eep_addr  = addr_q;
    eep_wdata = wdata_q;
    rdata     = rdata_q;
    done0     = (state_q == ST_DONE) && !port_q;
    done1     = (state_q == ST_DONE) && port_q;
`ifdef EEPROM_ARB_TIMEOUT_EN
    err0      = done0 && err_q;
    err1      = done1 && err_q;
`else
    err0      = 1'b0;
    err1      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Directed self-checking bench for eeprom_arbiter with a hand-driven engine model.
// Timeout expectations follow EEPROM_ARB_TIMEOUT_EN when it is defined.
module tb_eeprom_arbiter;

  localparam int AW  = 11;
  localparam int DW  = 8;
  localparam int TWR = 8;
  localparam int TMO = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          done0, done1, err0, err1, busy, eep_wr, eep_rd;
  logic [DW-1:0] rdata, eep_wdata;
  logic [AW-1:0] eep_addr;
  logic          eep_ack = 1'b0;
  logic [DW-1:0] eep_rdata = '0;

  int errors = 0;
  int checks = 0;
  int wrPulses = 0;
  int n;

  eeprom_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TWR_CYCLES(TWR), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata(rdata), .busy(busy), .eep_wr(eep_wr), .eep_rd(eep_rd),
    .eep_addr(eep_addr), .eep_wdata(eep_wdata),
    .eep_ack(eep_ack), .eep_rdata(eep_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (eep_wr) wrPulses++;
  endtask

  task automatic applyStimulus(input int port, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic req);
    if (port == 0) begin
      we0 = we; addr0 = addr; wdata0 = wdata; req0 = req;
    end else begin
      we1 = we; addr1 = addr; wdata1 = wdata; req1 = req;
    end
  endtask

  // Tick until a strobe appears; returns the number of cycles taken.
  task automatic waitStrobe(input string tag, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!(eep_wr || eep_rd) && cycles < 64);
    if (!(eep_wr || eep_rd)) checkOutput({tag, "_strobe_timeout"}, 0, 1);
  endtask

  // Called in the ISSUE cycle; acks after ackDelay idle cycles and checks the done pulse.
  task automatic completeTxn(input string tag, input int port, input logic [DW-1:0] ackData,
                             input int ackDelay);
    tick();
    repeat (ackDelay) tick();
    checkOutput({tag, "_no_early_done"}, {done1, done0}, 2'b00);
    eep_ack = 1'b1;
    eep_rdata = ackData;
    tick();
    checkOutput({tag, "_done0"}, done0, (port == 0));
    checkOutput({tag, "_done1"}, done1, (port == 1));
    eep_ack = 1'b0;
    eep_rdata = '0;
  endtask

  initial begin
    #2 RESET = 1'b0;
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_strobes", {eep_wr, eep_rd}, 0);
    checkOutput("rst_done", {done1, done0}, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_addr", eep_addr, 0);
    RESET = 1'b1;
    tick();

    // Port 0 write, ack after 20 cycles, then the write hold
    wrPulses = 0;
    applyStimulus(0, 1'b1, 11'h2A5, 8'h3C, 1'b1);
    tick();
    checkOutput("t1_wr", eep_wr, 1);
    checkOutput("t1_rd", eep_rd, 0);
    checkOutput("t1_addr", eep_addr, 11'h2A5);
    checkOutput("t1_wdata", eep_wdata, 8'h3C);
    completeTxn("t1", 0, 8'h00, 20);
    checkOutput("t1_err0", err0, 0);
    checkOutput("t1_wr_pulses", wrPulses, 1);
    applyStimulus(0, 1'b0, 11'h000, 8'h00, 1'b0);
    tick();
    checkOutput("t1_done_once", done0, 0);
    for (int k = 2; k <= TWR; k++) begin
      tick();
      checkOutput("t1_hold_busy", busy, 1);
    end
    tick();
    checkOutput("t1_idle", busy, 0);

    // Port 1 read, data returned with done, no hold afterwards
    applyStimulus(1, 1'b0, 11'h100, 8'h00, 1'b1);
    tick();
    checkOutput("t2_rd", eep_rd, 1);
    checkOutput("t2_wr", eep_wr, 0);
    checkOutput("t2_addr", eep_addr, 11'h100);
    completeTxn("t2", 1, 8'hA7, 3);
    checkOutput("t2_rdata", rdata, 8'hA7);
    checkOutput("t2_err1", err1, 0);
    applyStimulus(1, 1'b0, 11'h000, 8'h00, 1'b0);
    tick();
    checkOutput("t2_idle", busy, 0);
    checkOutput("t2_rdata_hold", rdata, 8'hA7);

    // Both ports requesting continuously: strict alternation starting at port 0
    applyStimulus(0, 1'b0, 11'h011, 8'h00, 1'b1);
    applyStimulus(1, 1'b0, 11'h122, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      waitStrobe("t3", n);
      checkOutput("t3_addr", eep_addr, (i % 2 == 0) ? 11'h011 : 11'h122);
      completeTxn("t3", i % 2, 8'(i + 1), 1);
      checkOutput("t3_rdata", rdata, 8'(i + 1));
    end
    applyStimulus(0, 1'b0, 11'h000, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 11'h000, 8'h00, 1'b0);
    tick();

    // Port 1 read arriving during the port 0 write hold
    applyStimulus(0, 1'b1, 11'h7FF, 8'hFF, 1'b1);
    waitStrobe("t4w", n);
    checkOutput("t4_wr", eep_wr, 1);
    checkOutput("t4_addr_max", eep_addr, 11'h7FF);
    checkOutput("t4_wdata", eep_wdata, 8'hFF);
    completeTxn("t4w", 0, 8'h00, 0);
    applyStimulus(0, 1'b0, 11'h000, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 11'h000, 8'h00, 1'b1);
    waitStrobe("t4r", n);
    checkOutput("t4_hold_latency", n, TWR + 2);
    checkOutput("t4_rd", eep_rd, 1);
    checkOutput("t4_addr_zero", eep_addr, 11'h000);
    completeTxn("t4r", 1, 8'h5A, 0);
    checkOutput("t4_rdata", rdata, 8'h5A);
    applyStimulus(1, 1'b0, 11'h000, 8'h00, 1'b0);

    // Move the pointer to port 1, then reset mid WAIT_ACK
    applyStimulus(0, 1'b0, 11'h033, 8'h00, 1'b1);
    waitStrobe("t5a", n);
    completeTxn("t5a", 0, 8'hC3, 0);
    applyStimulus(0, 1'b0, 11'h000, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 11'h155, 8'h00, 1'b1);
    waitStrobe("t5b", n);
    tick();
    tick();
    RESET = 1'b0;
    #1;
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_strobes", {eep_wr, eep_rd}, 0);
    checkOutput("t5_rst_addr", eep_addr, 0);
    checkOutput("t5_rst_rdata", rdata, 0);
    checkOutput("t5_rst_done", {done1, done0}, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    checkOutput("t5_rst_done2", {done1, done0}, 0);
    applyStimulus(0, 1'b0, 11'h044, 8'h00, 1'b1);
    waitStrobe("t5c", n);
    checkOutput("t5_prio0_addr", eep_addr, 11'h044);
    completeTxn("t5c", 0, 8'h99, 0);
    checkOutput("t5_rdata", rdata, 8'h99);
    applyStimulus(0, 1'b0, 11'h000, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 11'h000, 8'h00, 1'b0);
    tick();

    // Read that is never acknowledged
    applyStimulus(0, 1'b0, 11'h200, 8'h00, 1'b1);
    waitStrobe("t6", n);
`ifdef EEPROM_ARB_TIMEOUT_EN
    n = 0;
    do begin
      tick();
      n++;
    end while (!done0 && n < 40);
    checkOutput("t6_timeout_cycles", n, TMO + 1);
    checkOutput("t6_err0", err0, 1);
    checkOutput("t6_rdata_kept", rdata, 8'h99);
    applyStimulus(0, 1'b0, 11'h000, 8'h00, 1'b0);
    tick();
    checkOutput("t6_hold_busy", busy, 1);
    checkOutput("t6_done_once", done0, 0);
`else
    repeat (40) tick();
    checkOutput("t6_busy_stuck", busy, 1);
    checkOutput("t6_no_done", done0, 0);
    checkOutput("t6_no_err", err0, 0);
    applyStimulus(0, 1'b0, 11'h000, 8'h00, 1'b0);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    checkOutput("t6_recover_idle", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eeprom_arbiter.md
Name: eeprom_arbiter

Overview:
- Shares one serial EEPROM read/write engine between two independent requesters (port 0 = CPU, port 1 = config loader).
- Arbitrates with round-robin priority and latches the winning request.
- Issues one-cycle WR/RD strobes plus address/data to the engine and waits for its ACK.
- Returns read data and a done pulse to the winner, and enforces the EEPROM internal write-cycle gap before the next access.

Parameters:
ADDR_W, 11, EEPROM byte address width (matches engine ADDR).
DATA_W, 8, data width.
TWR_CYCLES, 5000, CLK cycles of mandatory idle after a write ACK (EEPROM internal write time).
TIMEOUT_CYCLES, 4096, CLK cycles to wait for ACK before abort (only with EEPROM_ARB_TIMEOUT_EN).

Ports:
CLK  in  1  system clock, all logic on posedge.
RESET  in  1  reset, asynchronous, active-low (0 = reset).
req0 / req1  in  1  request; held high until the matching done pulse.
we0 / we1  in  1  1 = write, 0 = read; sampled at grant.
addr0 / addr1  in  ADDR_W  byte address; sampled at grant.
wdata0 / wdata1  in  DATA_W  write data; sampled at grant.
done0 / done1  out  1  one-cycle completion pulse.
err0 / err1  out  1  valid with done; 1 = timeout abort.
rdata  out  DATA_W  read data, valid from the done pulse until the next read completes.
busy  out  1  high in every state except IDLE.
eep_wr / eep_rd  out  1  one-cycle start strobes to the engine.
eep_addr  out  ADDR_W  latched address to the engine.
eep_wdata  out  DATA_W  latched write data to the engine.
eep_ack  in  1  engine completion.
eep_rdata  in  DATA_W  engine read result, valid while eep_ack is high.

Behaviour:
- Reset (RESET low, async): state=IDLE, priority pointer=0, all outputs 0, rdata=0, counters cleared. Reset mid-transaction drops eep_wr/eep_rd immediately. No done pulse is issued for the aborted request.
- FSM states: IDLE, ISSUE, WAIT_ACK, DONE, WR_HOLD.
- IDLE:
  - If any req is high, grant one: the pointer port wins if requesting, otherwise the other port.
  - Latch we/addr/wdata of the winner into eep_addr/eep_wdata/op register, then go to ISSUE.
  - Sole requester: grant in the first IDLE cycle req is seen.
- ISSUE: drive eep_wr (op=write) or eep_rd (op=read) high for exactly one cycle, then go to WAIT_ACK. eep_addr/eep_wdata stay stable from ISSUE until DONE.
- WAIT_ACK: act on the first cycle eep_ack=1.
  - Read: capture eep_rdata into rdata.
  - Either op: go to DONE. Further ack-high cycles are ignored.
- DONE:
  - Pulse done of the granted port for one cycle; err=0.
  - Flip the pointer to the non-granted port.
  - Next state: WR_HOLD if op=write, else IDLE.
- WR_HOLD: count TWR_CYCLES cycles (0..TWR_CYCLES-1), then go to IDLE. No grant during hold, including reads.
- Request-to-issue latency = 1 cycle; ack-to-done = 1 cycle.
- A requester dropping req mid-transaction does not abort it; done still pulses.
- req of the just-served port still high in the cycle after done is treated as a new request.
- Both ports requesting every cycle strictly alternate 0,1,0,1.
- TWR_CYCLES=0: WR_HOLD lasts exactly 1 cycle.
- Addresses are passed through unmodified; no wrap logic in this block.

Optional Feature:
Macro EEPROM_ARB_TIMEOUT_EN.
- Defined:
  - WAIT_ACK runs a counter.
  - If eep_ack is not seen within TIMEOUT_CYCLES cycles, go to DONE with err=1 on the granted port; rdata is unchanged.
  - Then go to WR_HOLD regardless of op, so the engine gets recovery time.
  - The pointer still flips.
- Not defined: no counter, err0/err1 tied 0, WAIT_ACK waits indefinitely.

Decomposition:
- Shared package eeprom_pkg: FSM state encoding (one-hot, 5 bits), ADDR_W/DATA_W defaults, op encoding (OP_RD=0, OP_WR=1).
- One sub-module, eeprom_rr_arb2: combinational 2-way round-robin grant from req[1:0] and the pointer.
- FSM, latches, and counters stay in the top.

Test Plan:
- Port 0 write addr=0x2A5 data=0x3C, ack after 20 cycles -> one eep_wr pulse, eep_addr=0x2A5, eep_wdata=0x3C, done0 1 cycle after ack, busy high through TWR_CYCLES hold.
- Port 1 read addr=0x100, engine acks with eep_rdata=0xA7 -> eep_rd pulse, rdata=0xA7 with done1, err1=0, IDLE next cycle (no hold).
- req0 and req1 held high continuously for 4 transactions -> grant order 0,1,0,1; no done on the wrong port.
- Port 1 read request arrives during port 0 write hold -> no eep_rd until TWR_CYCLES elapse, then issued.
- RESET low for 1 cycle while in WAIT_ACK -> all outputs 0 asynchronously, no done; a fresh request afterwards completes normally with port 0 priority.
- With EEPROM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> done0 and err0 at cycle 17 after the strobe, then WR_HOLD; without the macro, busy stays high.
